rf_bypass_scoreboard: RTL and testbench

- Parametrised integer register file for the pipelined RV32I core; replaces the single-cycle two-read/one-write file.
- Adds configurable width, depth and read-port count, write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, issue marking) and writeback (writes, busy clear).

---
 rtl/rf_pkg.sv | 8 +
 rtl/rf_scoreboard.sv | 44 ++++
 rtl/rf_bypass_scoreboard.sv | 69 ++++++
 tb/tb_rf_bypass_scoreboard.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file geometry so decode, hazard and RF logic agree on it.
// Constants only, no logic.
package rf_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);
   localparam int REG_ZERO  = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with flush > issue > writeback-clear priority.
// Next-state visible one cycle after the edge; never stalls, no handshake.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic             flush,
   output logic [NREGS-1:0] busy_vec
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy_q;
      for (int i = 1; i < NREGS; i++) begin
         if (flush)
            busy_nxt[i] = 1'b0;
         else if (iss_en && (iss_addr == AW'(i)))
            busy_nxt[i] = 1'b1; // a new producer supersedes the retiring one
         else if (wr_en && (wr_addr == AW'(i)))
            busy_nxt[i] = 1'b0;
      end
      busy_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_q <= '0;
      else
         busy_q <= busy_nxt;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/rf_bypass_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
// Reads are zero-latency combinational, writes land on the edge; no backpressure.
module rf_bypass_scoreboard
   import rf_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int AW     = $clog2(NREGS),
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_live;

   assign wr_live = wr_en && (wr_addr != AW'(REG_ZERO));

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .flush    (flush),
      .busy_vec (busy_vec)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;

      assign addr = rd_addr[k*AW +: AW];
      assign hit  = (BYPASS != 0) && wr_live && (wr_addr == addr);

      assign rd_data[k*XLEN +: XLEN] = (addr == AW'(REG_ZERO)) ? '0 :
                                       hit                     ? wr_data :
                                                                 regs[addr];
      // Forwarded data is already current, so the hazard is resolved this cycle.
      assign rd_busy[k] = busy_vec[addr] & ~hit;
   end

endmodule

// File: tb/tb_rf_bypass_scoreboard.sv
// Directed bench: dut_b (BYPASS=1, NRD=4) and dut_n (BYPASS=0, NRD=2) share writeback/issue stimulus.
module tb_rf_bypass_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        iss_en = 1'b0;
   logic [4:0]  iss_addr = '0;
   logic        flush = 1'b0;

   logic [19:0]  rd_addr_b = '0;
   logic [127:0] rd_data_b;
   logic [3:0]   rd_busy_b;
   logic [31:0]  busy_vec_b;

   logic [9:0]  rd_addr_n = '0;
   logic [63:0] rd_data_n;
   logic [1:0]  rd_busy_n;
   logic [31:0] busy_vec_n;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rf_bypass_scoreboard #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(1)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_b)
   );

   rf_bypass_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_n), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      iss_en = 1'b0;
      flush  = 1'b0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
   endtask

   task automatic do_issue(input logic [4:0] a);
      iss_en = 1'b1; iss_addr = a;
   endtask

   task automatic test_reset();
      rd_addr_b[4:0] = 5'd5;
      rd_addr_n[4:0] = 5'd5;
      #1;
      vectors++;
      if (busy_vec_b !== 32'h0) begin
         miscompares++; $display("FAIL reset_busy_vec got %h want %h", busy_vec_b, 32'h0);
      end
      vectors++;
      if (rd_data_b[31:0] !== 32'h0) begin
         miscompares++; $display("FAIL reset_rd_data got %h want %h", rd_data_b[31:0], 32'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();
      do_write(5'd5, 32'hDEADBEEF);
      do_issue(5'd5);
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL pre_reset_reg5 got %h want %h", rd_data_b[31:0], 32'hDEADBEEF);
      end
      vectors++;
      if (busy_vec_b !== 32'h0000_0020) begin
         miscompares++; $display("FAIL pre_reset_busy got %h want %h", busy_vec_b, 32'h0000_0020);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin
         miscompares++; $display("FAIL midrun_reset_data got %h/%h want 0", rd_data_b[31:0], rd_data_n[31:0]);
      end
      vectors++;
      if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0 || rd_busy_b[0] !== 1'b0) begin
         miscompares++; $display("FAIL midrun_reset_busy got %h/%h want 0", busy_vec_b, busy_vec_n);
      end
      #1 rst = 1'b0;
      tick();
   endtask

   task automatic test_x0();
      rd_addr_b[4:0] = 5'd0;
      rd_addr_n[4:0] = 5'd0;
      do_write(5'd0, 32'hFFFFFFFF);
      do_issue(5'd0);
      #1;
      vectors++;
      if (rd_data_b[31:0] !== 32'h0) begin
         miscompares++; $display("FAIL x0_no_bypass got %h want %h", rd_data_b[31:0], 32'h0);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin
         miscompares++; $display("FAIL x0_read got %h/%h want 0", rd_data_b[31:0], rd_data_n[31:0]);
      end
      vectors++;
      if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
         miscompares++; $display("FAIL x0_busy got %h/%h want 0", busy_vec_b, busy_vec_n);
      end
   endtask

   task automatic test_bypass();
      do_issue(5'd7);
      tick();
      idle();
      rd_addr_b[4:0] = 5'd7;
      rd_addr_n[4:0] = 5'd7;
      do_write(5'd7, 32'h12345678);
      #1;
      vectors++;
      if (rd_data_b[31:0] !== 32'h12345678) begin
         miscompares++; $display("FAIL bypass_data got %h want %h", rd_data_b[31:0], 32'h12345678);
      end
      vectors++;
      if (rd_busy_b[0] !== 1'b0) begin
         miscompares++; $display("FAIL bypass_busy got %b want 0", rd_busy_b[0]);
      end
      vectors++;
      if (rd_data_n[31:0] !== 32'h0) begin
         miscompares++; $display("FAIL nobypass_old got %h want %h", rd_data_n[31:0], 32'h0);
      end
      vectors++;
      if (rd_busy_n[0] !== 1'b1) begin
         miscompares++; $display("FAIL nobypass_busy got %b want 1", rd_busy_n[0]);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rd_data_n[31:0] !== 32'h12345678) begin
         miscompares++; $display("FAIL nobypass_after got %h want %h", rd_data_n[31:0], 32'h12345678);
      end
      vectors++;
      if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
         miscompares++; $display("FAIL bypass_clear got %h/%h want 0", busy_vec_b, busy_vec_n);
      end
   endtask

   task automatic test_set_clear();
      rd_addr_b[9:5] = 5'd3;
      do_issue(5'd3);
      tick();
      idle();
      #1;
      vectors++;
      if (busy_vec_b !== 32'h0000_0008 || rd_busy_b[1] !== 1'b1) begin
         miscompares++; $display("FAIL sb_set got %h/%b want 00000008/1", busy_vec_b, rd_busy_b[1]);
      end
      tick();
      vectors++;
      if (busy_vec_b !== 32'h0000_0008) begin
         miscompares++; $display("FAIL sb_hold got %h want %h", busy_vec_b, 32'h0000_0008);
      end
      do_write(5'd3, 32'h000000A5);
      tick();
      idle();
      #1;
      vectors++;
      if (busy_vec_b !== 32'h0) begin
         miscompares++; $display("FAIL sb_clear got %h want %h", busy_vec_b, 32'h0);
      end
      vectors++;
      if (rd_data_b[63:32] !== 32'h000000A5) begin
         miscompares++; $display("FAIL sb_wdata got %h want %h", rd_data_b[63:32], 32'h000000A5);
      end
   endtask

   task automatic test_collision();
      rd_addr_b[14:10] = 5'd9;
      do_issue(5'd9);
      tick();
      idle();
      do_issue(5'd9);
      do_write(5'd9, 32'hCAFE0009);
      tick();
      idle();
      #1;
      vectors++;
      if (busy_vec_b !== 32'h0000_0200 || busy_vec_n !== 32'h0000_0200) begin
         miscompares++; $display("FAIL collide_busy got %h/%h want %h", busy_vec_b, busy_vec_n, 32'h0000_0200);
      end
      vectors++;
      if (rd_data_b[95:64] !== 32'hCAFE0009 || rd_busy_b[2] !== 1'b1) begin
         miscompares++; $display("FAIL collide_data got %h/%b want cafe0009/1", rd_data_b[95:64], rd_busy_b[2]);
      end
   endtask

   task automatic test_flush();
      do_issue(5'd2); tick();
      do_issue(5'd4); tick();
      do_issue(5'd6); tick();
      idle();
      #1;
      vectors++;
      if (busy_vec_b !== 32'h0000_0254) begin
         miscompares++; $display("FAIL pre_flush got %h want %h", busy_vec_b, 32'h0000_0254);
      end
      flush = 1'b1;
      do_issue(5'd8);
      do_write(5'd2, 32'h00000022);
      tick();
      idle();
      rd_addr_b[4:0] = 5'd2;
      #1;
      vectors++;
      if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
         miscompares++; $display("FAIL flush_busy got %h/%h want 0", busy_vec_b, busy_vec_n);
      end
      vectors++;
      if (rd_data_b[31:0] !== 32'h00000022) begin
         miscompares++; $display("FAIL flush_write got %h want %h", rd_data_b[31:0], 32'h00000022);
      end
   endtask

   task automatic test_alias();
      for (int k = 0; k < 4; k++) rd_addr_b[k*5 +: 5] = 5'd4;
      do_write(5'd4, 32'h44444444);
      tick();
      idle();
      #1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_data_b[k*32 +: 32] !== 32'h44444444) begin
            miscompares++; $display("FAIL alias_port%0d got %h want %h", k, rd_data_b[k*32 +: 32], 32'h44444444);
         end
      end
      do_issue(5'd4);
      tick();
      idle();
      do_write(5'd4, 32'h55555555);
      #1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (rd_data_b[k*32 +: 32] !== 32'h55555555 || rd_busy_b[k] !== 1'b0) begin
            miscompares++; $display("FAIL alias_bypass_port%0d got %h/%b want 55555555/0", k, rd_data_b[k*32 +: 32], rd_busy_b[k]);
         end
      end
      tick();
      idle();
   endtask

   initial begin
      test_reset();
      test_x0();
      test_bypass();
      test_set_clear();
      test_collision();
      test_flush();
      test_alias();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
